// File: rtl/first_nios2_system_irq_ctrl.sv
// Interrupt aggregator for the first_nios2_system design.
// Collects up to 16 peripheral interrupt lines, latches rising edges or passes
// levels per source, masks and priority-encodes them (bit 0 highest), and drives
// one registered interrupt request to the CPU. Software access is a 16-bit
// Avalon-MM slave in the interval-timer style (readdata registered every cycle).
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   address[2:0]          register word address
//   chipselect, write_n   write when chipselect=1 and write_n=0
//   writedata[15:0]       write data
//   readdata[15:0]        registered read data (mux of address, 1-cycle latency)
//   irq_in[NUM_SOURCES]   interrupt sources, synchronous to clk
//   irq                   registered interrupt request
//
// Register map: 0 PENDING (W1C), 1 ENABLE, 2 MODE (1=edge), 3 ACTIVE_ID (RO),
//               4 FORCE (W1S, reads 0), 5 OVERRUN (any write clears), 6/7 reserved.
module first_nios2_system_irq_ctrl #(
  parameter int NUM_SOURCES = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic [15:0]            writedata,
  output logic [15:0]            readdata,
  input  logic [NUM_SOURCES-1:0] irq_in,
  output logic                   irq
);
  localparam int N = NUM_SOURCES;

  logic [N-1:0] enable_q, enable_d;
  logic [N-1:0] mode_q, mode_d;
  logic [N-1:0] edge_pend_q, edge_pend_d;
  logic [N-1:0] soft_pend_q, soft_pend_d;
  logic [N-1:0] prev_q;
  logic [15:0]  ovr_q, ovr_d;
  logic [15:0]  readdata_q, readdata_d;
  logic         irq_q, irq_d;

  logic         wr;
  logic [N-1:0] wd, w1c, edge_det, pend_vec, act_vec;
  logic         overrun;
  logic [3:0]   act_id;
  logic         act_vld;
  logic         unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[N-1:0];
  assign unused_wd = ^writedata;  // upper bits ignored when N < 16

  assign w1c      = (wr && address == 3'd0) ? wd : '0;
  assign edge_det = irq_in & ~prev_q & mode_q;
  assign pend_vec = edge_pend_q | soft_pend_q | (irq_in & ~mode_q);
  assign act_vec  = pend_vec & enable_q;
  // A new edge on an already-pending source is lost unless that bit is being
  // cleared this cycle, in which case the edge simply re-arms it.
  assign overrun  = |(edge_det & edge_pend_q & ~w1c);

  // Lowest set index wins: scan from the top so lower indices overwrite.
  always_comb begin
    act_id = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (act_vec[i]) act_id = 4'(i);
    end
    act_vld = |act_vec;
  end

  always_comb begin
    enable_d    = enable_q;
    mode_d      = mode_q;
    soft_pend_d = soft_pend_q & ~w1c;
    edge_pend_d = edge_pend_q & ~w1c;
    ovr_d       = ovr_q;

    if (wr && address == 3'd1) enable_d = wd;
    if (wr && address == 3'd2) begin
      mode_d      = wd;
      // A source changing mode drops any stale latched edge.
      edge_pend_d = edge_pend_d & ~(mode_q ^ wd);
    end
    if (wr && address == 3'd4) soft_pend_d = soft_pend_d | wd;
    // Set after the clears so a same-cycle edge beats W1C / mode change.
    edge_pend_d = edge_pend_d | edge_det;

    if (wr && address == 3'd5) ovr_d = overrun ? 16'd1 : 16'd0;
    else if (overrun && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;

    case (address)
      3'd0:    readdata_d = 16'(pend_vec);
      3'd1:    readdata_d = 16'(enable_q);
      3'd2:    readdata_d = 16'(mode_q);
      3'd3:    readdata_d = {act_vld, 11'b0, act_id};
      3'd5:    readdata_d = ovr_q;
      default: readdata_d = 16'h0000;
    endcase

    irq_d = act_vld;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable_q    <= '0;
      mode_q      <= '0;
      edge_pend_q <= '0;
      soft_pend_q <= '0;
      prev_q      <= '0;
      ovr_q       <= 16'h0000;
      readdata_q  <= 16'h0000;
      irq_q       <= 1'b0;
    end else begin
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      edge_pend_q <= edge_pend_d;
      soft_pend_q <= soft_pend_d;
      prev_q      <= irq_in;
      ovr_q       <= ovr_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_first_nios2_system_irq_ctrl.sv
module tb_first_nios2_system_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_in;
  logic        irq;

  int checks = 0;
  int errors = 0;

  first_nios2_system_irq_ctrl #(.NUM_SOURCES(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_in(irq_in), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
    logic [7:0]  ii;
    logic [15:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[16];

  // One clock: drive bus, let the edge happen, sample 1 time unit later.
  task automatic step(input logic w, input logic [2:0] a, input logic [15:0] d);
    chipselect = w;
    write_n    = ~w;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    step(1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, a, 16'h0000);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'h0000; irq_in = 8'h00;

    // Reset / basic level source table.
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 3'(i), 16'h0, 8'h00, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 3'd1, 16'h0001, 8'h00, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 16'h0000, 8'h01, 16'h0001, 1'b1};
    tbl[10] = '{1'b0, 3'd0, 16'h0000, 8'h01, 16'h0001, 1'b1};
    tbl[11] = '{1'b0, 3'd3, 16'h0000, 8'h01, 16'h8000, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 16'h0000, 8'h01, 16'h0001, 1'b1};
    tbl[13] = '{1'b0, 3'd0, 16'h0000, 8'h01, 16'h0001, 1'b1};
    tbl[14] = '{1'b0, 3'd0, 16'h0000, 8'h00, 16'h0000, 1'b0};
    tbl[15] = '{1'b0, 3'd3, 16'h0000, 8'h00, 16'h0000, 1'b0};

    rd(3'd0); rd(3'd0);
    chk("reset_readdata", readdata, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      irq_in = tbl[i].ii;
      step(tbl[i].w, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {15'b0, irq}, {15'b0, tbl[i].exp_irq});
    end

    // Edge source 2: two-cycle latency, W1C drops it.
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in = 8'h04; rd(3'd0);
    chk("edge_irq_first", {15'b0, irq}, 16'h0000);
    irq_in = 8'h00; rd(3'd0);
    chk("edge_pend", readdata, 16'h0004);
    chk("edge_irq", {15'b0, irq}, 16'h0001);
    rd(3'd3);
    chk("edge_active_id", readdata, 16'h8002);
    chk("edge_irq_held", {15'b0, irq}, 16'h0001);
    wr(3'd0, 16'h0004);
    rd(3'd3);
    chk("w1c_active_id", readdata, 16'h0000);
    chk("w1c_irq", {15'b0, irq}, 16'h0000);

    // Overrun on source 3, then W1C racing a new edge.
    wr(3'd2, 16'h0008);
    wr(3'd1, 16'h0008);
    irq_in = 8'h08; rd(3'd5);
    irq_in = 8'h00; rd(3'd5);
    irq_in = 8'h08; rd(3'd5);
    irq_in = 8'h00; rd(3'd5);
    chk("overrun_one", readdata, 16'h0001);
    irq_in = 8'h08; wr(3'd0, 16'h0008);
    irq_in = 8'h00; rd(3'd0);
    chk("race_pend", readdata, 16'h0008);
    rd(3'd5);
    chk("race_overrun", readdata, 16'h0001);

    // Saturation: sources 3 and 4 rise on alternate cycles -> overrun every cycle.
    wr(3'd2, 16'h0018);
    wr(3'd5, 16'h0000);
    for (int k = 0; k < 100; k++) begin
      irq_in = (k % 2 == 0) ? 8'h10 : 8'h08;
      rd(3'd0);
    end
    rd(3'd5);
    chk("overrun_count99", readdata, 16'd99);
    for (int k = 100; k < 65600; k++) begin
      irq_in = (k % 2 == 0) ? 8'h10 : 8'h08;
      rd(3'd0);
    end
    rd(3'd5);
    chk("overrun_sat", readdata, 16'hFFFF);
    irq_in = 8'h10; wr(3'd5, 16'h1234);
    rd(3'd5);
    chk("overrun_clr_race", readdata, 16'h0001);
    wr(3'd5, 16'h0000);
    rd(3'd5);
    chk("overrun_clr", readdata, 16'h0000);

    // Level priority between sources 1 and 5.
    irq_in = 8'h00;
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0022);
    wr(3'd0, 16'hFFFF);
    irq_in = 8'h22; rd(3'd3);
    chk("prio_id1", readdata, 16'h8001);
    chk("prio_irq", {15'b0, irq}, 16'h0001);
    wr(3'd1, 16'h0020);
    rd(3'd3);
    chk("prio_id5", readdata, 16'h8005);
    wr(3'd1, 16'hFFFF);
    rd(3'd1);
    chk("enable_unused_bits", readdata, 16'h00FF);

    // Software force, then reset mid-operation.
    irq_in = 8'h00;
    wr(3'd1, 16'h0080);
    wr(3'd4, 16'h0080);
    rd(3'd0);
    chk("force_pend", readdata, 16'h0080);
    chk("force_irq", {15'b0, irq}, 16'h0001);
    rd(3'd4);
    chk("force_reads0", readdata, 16'h0000);
    reset_n = 1'b0; rd(3'd0);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    reset_n = 1'b1; rd(3'd0);
    chk("rst_pend", readdata, 16'h0000);
    chk("rst_irq_after", {15'b0, irq}, 16'h0000);
    rd(3'd1);
    chk("rst_enable", readdata, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/first_nios2_system_irq_ctrl.md
# first_nios2_system_irq_ctrl

Interrupt aggregation stage directly downstream of the interval timer and other Avalon peripherals in the first_nios2_system design. It collects up to 16 per-peripheral interrupt lines, including the timer's `irq`, and latches edges or passes levels. It masks and priority-encodes them, then drives one registered interrupt request to the Nios II. Software accesses it through a 16-bit Avalon-MM slave with the same register access style as the timer.

## Interface
- NUM_SOURCES, 8, number of interrupt inputs used (1..16); unused bits of every register read 0 and ignore writes.
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs on a cycle with chipselect=1 and write_n=0.
- writedata  input  16  write data.
- readdata  output  16  registered read data.
- irq_in  input  NUM_SOURCES  interrupt sources, synchronous to clk; bit 0 has the highest priority.
- irq  output  1  registered interrupt request to the CPU.

## Operation
- Registers, by address:
  - 0 PENDING:
    - Read returns pend_vec.
    - A write of 1 clears edge_pend[i] and soft_pend[i]; a write of 0 has no effect.
    - Level-mode bits reflect irq_in and cannot be cleared.
  - 1 ENABLE: R/W mask.
  - 2 MODE: R/W; 1 = rising-edge source, 0 = level source.
  - 3 ACTIVE_ID:
    - Read returns {valid, 11'b0, id[3:0]}.
    - id is the lowest index i with pend_vec[i]&ENABLE[i]; valid = any such i; id = 0 when none.
    - Writes are ignored.
  - 4 FORCE: read 0; a write of 1 sets soft_pend[i].
  - 5 OVERRUN: read returns a 16-bit saturating counter; any write clears it.
  - 6, 7: read 0; writes ignored.
- prev_in <= irq_in every cycle. edge_det[i] = irq_in[i] & ~prev_in[i] & MODE[i].
- edge_pend[i] is set on edge_det[i]. Set wins over a same-cycle W1C.
- Writing MODE clears edge_pend for every bit whose MODE value changes.
- pend_vec = edge_pend | soft_pend | (irq_in & ~MODE).
- Overrun: overrun_cycle = any i with edge_det[i] & edge_pend[i] & ~(W1C clearing bit i this cycle).
  - The counter increments by 1 per overrun cycle, regardless of how many sources overrun, and saturates at 0xFFFF.
  - A clear and an overrun in the same cycle leave the counter at 1.
- irq <= |(pend_vec & ENABLE) every cycle.
- readdata <= mux(address) every cycle, independent of chipselect, as the timer does. Reads have no side effects.

## Timing
- Reset (reset_n=0 sampled at a clk edge): ENABLE, MODE, edge_pend, soft_pend, OVERRUN, prev_in, readdata and irq all become 0.
  - prev_in resets to 0, so an edge-mode input already high at the first clock after reset registers as an edge. MODE resets to level, so this only matters after software selects edge mode.
- A write takes effect at the clk edge that samples it. The new value is visible in readdata one cycle later, when the address is held.
- Read latency: readdata reflects state at the clk edge after address is presented (1 cycle).
- Level source: irq_in[i] high at edge k, with the source enabled, gives irq=1 after edge k, i.e. 1 cycle latency. Dropping the input drops irq 1 cycle later.
- Edge source: a rise sampled at edge k sets edge_pend after edge k. irq=1 after edge k+1, i.e. 2 cycles from the rise.
- ENABLE write: irq reflects the new mask one cycle after the write edge.
- W1C of the last pending bit: irq falls one cycle after the write edge unless a new edge arrives at the same edge.
- Reset mid-operation: all pending state is lost; there is no replay.

## Test plan
- Reset, then read addresses 0..7 -> every readdata 0x0000, irq=0.
- ENABLE=0x0001, MODE=0, pulse irq_in[0] high for 5 cycles -> irq high for exactly 5 cycles, delayed 1 cycle; PENDING reads 0x0001 while high.
- MODE=0x0004, ENABLE=0x0004, 1-cycle pulse on irq_in[2] -> irq=1 two cycles later and held; ACTIVE_ID=0x8002; W1C 0x0004 -> irq=0 next cycle, ACTIVE_ID=0x0000.
- Edge source 3 enabled, pulse twice without clearing -> OVERRUN=1; W1C on the same cycle as the third rising edge -> PENDING bit 3 stays 1 and OVERRUN stays 1; force 0xFFFF+ overruns -> the counter saturates at 0xFFFF; write addr 5 -> 0.
- Level sources 1 and 5 high together, ENABLE=0x0022 -> ACTIVE_ID=0x8001; ENABLE=0x0020 -> ACTIVE_ID=0x8005.
- FORCE=0x0080 with ENABLE=0x0080 -> irq=1 next cycle; reset_n=0 for one cycle -> irq=0 and PENDING=0x0000.
